// File: rtl/histo_readout.sv
// histo_readout: serializes the photon-bin and inter-photon-interval histograms as a checksummed byte frame, optionally followed by a clear pulse
module histo_readout #(
  parameter int NBINS = 8,
  parameter int NIPI = 64,
  parameter int CLEAR_HOLD = 80
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic [NBINS*32-1:0]   histo,
  input  logic [NIPI*32-1:0]    ipihist,
  input  logic                  cmd_valid,
  input  logic [7:0]            cmd,
  output logic                  cmd_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  resethist,
  output logic                  busy
);
  typedef enum logic [3:0] {IDLE, HDR, TYPE, COUNT, LOAD, BYTE, CSUM, CLEAR, HOLD} state_t;
  state_t state, state_n;
  logic [(NBINS+NIPI)*32-1:0] words;
  logic clr, v, xfer, accept, unused;
  logic [1:0] sel, b;
  logic [7:0] w, w_last, count, csum, d;
  logic [31:0] shadow;
  logic [15:0] hcnt;
  assign unused = ^cmd[6:2];
  // histo words occupy indices 0..NBINS-1, ipihist words follow
  assign words = {ipihist, histo};
  assign count = sel == 2'b01 ? 8'(NBINS) : sel == 2'b10 ? 8'(NIPI) : 8'(NBINS + NIPI);
  assign w_last = sel == 2'b01 ? 8'(NBINS - 1) : 8'(NBINS + NIPI - 1);
  assign v = state == HDR || state == TYPE || state == COUNT || state == BYTE || state == CSUM;
  assign d = state == HDR ? 8'hA5 :
             state == TYPE ? {clr, 5'b0, sel} :
             state == COUNT ? count :
             state == BYTE ? shadow[8*b +: 8] :
             state == CSUM ? csum : 8'h00;
  assign xfer = v & tx_ready;
  assign accept = cmd_valid & cmd_ready;
  assign cmd_ready = state == IDLE && !rst;
  assign busy = state != IDLE && !rst;
  assign tx_valid = v && !rst;
  assign tx_data = rst ? 8'h00 : d;
  assign resethist = state == CLEAR && !rst;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && cmd[1:0] != 2'b00) state_n = HDR;
      HDR:     if (xfer) state_n = TYPE;
      TYPE:    if (xfer) state_n = COUNT;
      COUNT:   if (xfer) state_n = LOAD;
      LOAD:    state_n = BYTE;
      BYTE:    if (xfer && b == 2'd3) state_n = w == w_last ? CSUM : LOAD;
      CSUM:    if (xfer) state_n = clr ? CLEAR : IDLE;
      CLEAR:   state_n = HOLD;
      HOLD:    if (hcnt == 16'(CLEAR_HOLD - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= IDLE;
      clr <= 1'b0;
      sel <= 2'b00;
      w <= 8'd0;
      b <= 2'd0;
      shadow <= 32'd0;
      csum <= 8'd0;
      hcnt <= 16'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        clr <= cmd[7];
        sel <= cmd[1:0];
        w <= cmd[1:0] == 2'b10 ? 8'(NBINS) : 8'd0;
        csum <= 8'd0;
      end
      if (xfer && (state == TYPE || state == COUNT || state == BYTE)) csum <= csum + d;
      if (state == LOAD) begin
        shadow <= words[32*w +: 32];
        b <= 2'd0;
      end
      if (state == BYTE && xfer) begin
        b <= b + 2'd1;
        if (b == 2'd3) w <= w + 8'd1;
      end
      hcnt <= state == HOLD ? hcnt + 16'd1 : 16'd0;
    end
  end
endmodule

// File: tb/tb_histo_readout.sv
// tb_histo_readout: table-driven frame checks plus hand-written reset, no-op and atomic-sampling sequences
module tb_histo_readout;
  localparam int NBINS = 8, NIPI = 64, CLEAR_HOLD = 80;
  typedef struct {
    logic [7:0] cmd;
    int len;
    logic [7:0] typ, cnt, csum;
    bit rnd, clr;
  } vec_t;
  logic clkin = 0, rst = 1, cmd_valid = 0, tx_ready = 1;
  logic [7:0] cmd = 0, tx_data;
  logic [NBINS*32-1:0] histo;
  logic [NIPI*32-1:0] ipi_pat, ipihist;
  logic cmd_ready, tx_valid, resethist, busy;
  logic rnd = 0, bump_en = 0, ones = 0;
  logic [31:0] bump = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] rx[$];
  int rx_cyc[$], rh_cyc[$];
  int last_busy = -1, bstart = -1, stall_bad = 0, stall_n = 0, rdy_bad = 0;
  logic [31:0] bump_at[0:65535];
  logic pv = 0, pr = 0, pb = 0;
  logic [7:0] pd = 0;
  vec_t vt[6];

  always #5 clkin = ~clkin;
  always_comb begin
    ipihist = ipi_pat;
    if (bump_en) ipihist[5*32 +: 32] = bump;
  end

  histo_readout #(.NBINS(NBINS), .NIPI(NIPI), .CLEAR_HOLD(CLEAR_HOLD)) dut (
    .clkin(clkin), .rst(rst), .histo(histo), .ipihist(ipihist),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .resethist(resethist), .busy(busy));

  initial forever begin
    @(posedge clkin);
    #1;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bump = bump + 32'd1;
  end

  initial forever begin
    @(negedge clkin);
    cyc++;
    bump_at[cyc % 65536] = bump;
    if (tx_valid && tx_ready) begin
      rx.push_back(tx_data);
      rx_cyc.push_back(cyc);
    end
    if (resethist) rh_cyc.push_back(cyc);
    if (busy) last_busy = cyc;
    if (busy && !pb) bstart = cyc;
    if (busy && cmd_ready) rdy_bad++;
    if (pv && !pr) begin
      stall_n++;
      if (!tx_valid || tx_data != pd) stall_bad++;
    end
    pv = tx_valid; pr = tx_ready; pd = tx_data; pb = busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_n;
    @(negedge clkin);
    #1;
  endtask

  function automatic logic [31:0] model(input int w);
    return ones ? 32'hFFFFFFFF : (w < NBINS ? 32'h11223300 + 32'(w) : 32'h04030200 + 32'(w - NBINS));
  endfunction

  task automatic send(input logic [7:0] c, output int acc);
    bit ok = 0;
    acc = -1;
    @(posedge clkin);
    #1;
    cmd = c;
    cmd_valid = 1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick_n;
      if (cmd_ready) begin
        acc = cyc;
        ok = 1;
      end
    end
    if (!ok) check("accept timeout", 0, 1);
    @(posedge clkin);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input int acc);
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick_n;
      if (!busy && cyc > acc + 1) done = 1;
    end
    check("idle timeout", longint'(busy), 0);
  endtask

  task automatic check_frame(input vec_t e, input int st, rh0, sb0, sn0, acc);
    int n = rx.size() - st;
    int bad = 0;
    int w0 = e.cmd[1:0] == 2'b10 ? NBINS : 0;
    int cc;
    check($sformatf("len %0h", e.cmd), n, e.len);
    if (n == e.len) begin
      cc = rx_cyc[st + n - 1];
      check($sformatf("hdr %0h", e.cmd), rx[st], 8'hA5);
      check($sformatf("type %0h", e.cmd), rx[st+1], e.typ);
      check($sformatf("count %0h", e.cmd), rx[st+2], e.cnt);
      check($sformatf("csum %0h", e.cmd), rx[st+n-1], e.csum);
      for (int k = 0; k < int'(e.cnt); k++) begin
        logic [31:0] ew = model(w0 + k);
        for (int j = 0; j < 4; j++) if (rx[st+3+4*k+j] != ew[8*j +: 8]) bad++;
      end
      check($sformatf("data bytes wrong %0h", e.cmd), bad, 0);
      check($sformatf("latency %0h", e.cmd), bstart, acc + 1);
      if (!e.rnd) check($sformatf("duration %0h", e.cmd), cc - rx_cyc[st] + 1, 4 + 5 * int'(e.cnt));
      else check($sformatf("stalls seen %0h", e.cmd), longint'(stall_n > sn0), 1);
      check($sformatf("stall hold %0h", e.cmd), stall_bad - sb0, 0);
      check($sformatf("clear pulses %0h", e.cmd), rh_cyc.size() - rh0, e.clr ? 1 : 0);
      if (e.clr && rh_cyc.size() > rh0) check($sformatf("clear cycle %0h", e.cmd), rh_cyc[rh0], cc + 1);
      check($sformatf("busy end %0h", e.cmd), last_busy, e.clr ? cc + 1 + CLEAR_HOLD : cc);
    end
  endtask

  initial begin
    int st, rh0, sb0, sn0, acc;
    logic [31:0] w5;
    vt[0] = '{8'h01, 36, 8'h01, 8'h08, 8'h55, 1'b0, 1'b0};
    vt[1] = '{8'h02, 260, 8'h02, 8'h40, 8'h62, 1'b1, 1'b0};
    vt[2] = '{8'h03, 292, 8'h03, 8'h48, 8'hB7, 1'b0, 1'b0};
    vt[3] = '{8'h83, 292, 8'h83, 8'h48, 8'h37, 1'b1, 1'b1};
    vt[4] = '{8'h7D, 36, 8'h01, 8'h08, 8'h55, 1'b0, 1'b0};
    vt[5] = '{8'h81, 36, 8'h81, 8'h08, 8'hD5, 1'b1, 1'b1};
    for (int i = 0; i < NBINS; i++) histo[32*i +: 32] = 32'h11223300 + 32'(i);
    for (int i = 0; i < NIPI; i++) ipi_pat[32*i +: 32] = 32'h04030200 + 32'(i);
    cmd_valid = 1;
    cmd = 8'h01;
    repeat (3) @(posedge clkin);
    tick_n;
    check("rst tx_valid", longint'(tx_valid), 0);
    check("rst tx_data", tx_data, 0);
    check("rst busy", longint'(busy), 0);
    check("rst cmd_ready", longint'(cmd_ready), 0);
    check("rst resethist", longint'(resethist), 0);
    @(posedge clkin);
    #1;
    rst = 0;
    cmd_valid = 0;
    tick_n;
    check("cmd_ready after rst", longint'(cmd_ready), 1);
    repeat (5) tick_n;
    check("cmd under rst ignored", rx.size(), 0);

    foreach (vt[i]) begin
      rnd = vt[i].rnd;
      st = rx.size(); rh0 = rh_cyc.size(); sb0 = stall_bad; sn0 = stall_n;
      send(vt[i].cmd, acc);
      wait_idle(acc);
      rnd = 0;
      check_frame(vt[i], st, rh0, sb0, sn0, acc);
    end

    // no-op command, then a 0x01 held valid right behind it
    st = rx.size(); rh0 = rh_cyc.size(); sb0 = stall_bad; sn0 = stall_n;
    @(posedge clkin);
    #1;
    cmd = 8'h00;
    cmd_valid = 1;
    tick_n;
    check("noop ready", longint'(cmd_ready), 1);
    @(posedge clkin);
    #1;
    cmd = 8'h01;
    tick_n;
    check("noop busy", longint'(busy), 0);
    check("noop ready again", longint'(cmd_ready), 1);
    acc = cyc;
    @(posedge clkin);
    #1;
    cmd_valid = 0;
    wait_idle(acc);
    check_frame(vt[0], st, rh0, sb0, sn0, acc);

    // word 5 of ipihist changes every cycle; it must be captured whole at its LOAD cycle
    bump_en = 1;
    st = rx.size();
    send(8'h02, acc);
    wait_idle(acc);
    bump_en = 0;
    check("torn len", rx.size() - st, 260);
    if (rx.size() - st == 260) begin
      w5 = {rx[st+26], rx[st+25], rx[st+24], rx[st+23]};
      check("word5 first byte cycle", rx_cyc[st+23] - rx_cyc[st], 29);
      check("word5 atomic", w5, bump_at[(rx_cyc[st+23] - 1) % 65536]);
      check("word6 intact", {rx[st+30], rx[st+29], rx[st+28], rx[st+27]}, model(NBINS + 6));
    end

    // reset while the 10th byte of a clearing dump is on the wire
    st = rx.size(); rh0 = rh_cyc.size();
    send(8'h83, acc);
    for (int i = 0; i < 100 && rx.size() - st < 9; i++) tick_n;
    @(posedge clkin);
    #1;
    rst = 1;
    tick_n;
    check("mid rst tx_valid", longint'(tx_valid), 0);
    check("mid rst busy", longint'(busy), 0);
    check("mid rst cmd_ready", longint'(cmd_ready), 0);
    @(posedge clkin);
    #1;
    rst = 0;
    tick_n;
    check("post rst tx_valid", longint'(tx_valid), 0);
    check("post rst cmd_ready", longint'(cmd_ready), 1);
    repeat (CLEAR_HOLD + 20) tick_n;
    check("abandoned bytes", rx.size() - st, 9);
    check("abandoned clear", rh_cyc.size() - rh0, 0);
    st = rx.size(); rh0 = rh_cyc.size(); sb0 = stall_bad; sn0 = stall_n;
    send(8'h01, acc);
    wait_idle(acc);
    check_frame(vt[0], st, rh0, sb0, sn0, acc);

    // all-ones counts exercise checksum wrap
    ones = 1;
    histo = '1;
    ipi_pat = '1;
    st = rx.size(); rh0 = rh_cyc.size(); sb0 = stall_bad; sn0 = stall_n;
    send(8'h03, acc);
    wait_idle(acc);
    check_frame('{8'h03, 292, 8'h03, 8'h48, 8'h2B, 1'b0, 1'b0}, st, rh0, sb0, sn0, acc);

    check("cmd_ready while busy", rdy_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
